// File: rtl/fact_cu.sv
// Factorial control unit: Moore FSM sequencing counter/product-register datapath.
// Optional MULT-cycle counter on iter_cnt is enabled by defining FACT_CU_ITER_CNT_EN.
module fact_cu #(
  parameter int unsigned ITER_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  gt_in,
  input  logic                  gt,
  output logic                  load_cnt,
  output logic                  en_cnt,
  output logic                  load_reg,
  output logic                  sel,
  output logic                  oe,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            state,
  output logic [ITER_WIDTH-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    MULT  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t cur, nxt;

  always_ff @(posedge clk) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt      = IDLE;
    load_cnt = 1'b0;
    en_cnt   = 1'b0;
    load_reg = 1'b0;
    sel      = 1'b0;
    oe       = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (cur)
      IDLE: begin
        if (go) nxt = gt_in ? ERR : LOAD;
        else    nxt = IDLE;
      end
      LOAD: begin
        load_cnt = 1'b1;
        load_reg = 1'b1;
        sel      = 1'b1;
        nxt      = CHECK;
      end
      CHECK: nxt = gt ? MULT : DONE;
      MULT: begin
        en_cnt   = 1'b1;
        load_reg = 1'b1;
        nxt      = CHECK;
      end
      DONE: begin
        done = 1'b1;
        oe   = 1'b1;
        nxt  = go ? DONE : IDLE;
      end
      ERR: begin
        err = 1'b1;
        nxt = go ? ERR : IDLE;
      end
      // Encodings 6 and 7 fall through to IDLE with outputs at their defaults.
      default: nxt = IDLE;
    endcase
  end

  assign state = cur;

`ifdef FACT_CU_ITER_CNT_EN
  logic [ITER_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (cur == LOAD)
      cnt <= '0;
    else if (cur == MULT && cnt != '1)
      cnt <= cnt + ITER_WIDTH'(1);
  end

  assign iter_cnt = cnt;
`else
  assign iter_cnt = '0;
`endif

endmodule

// File: tb/tb_fact_cu.sv
// Directed self-checking bench for fact_cu; a second instance with ITER_WIDTH=2
// shares the stimulus to exercise counter saturation.
module tb_fact_cu;
  logic clk = 1'b0;
  logic rst, go, gt_in, gt;
  logic load_cnt, en_cnt, load_reg, sel, oe, done, err;
  logic [2:0] state;
  logic [3:0] iter_cnt;
  logic load_cnt2, en_cnt2, load_reg2, sel2, oe2, done2, err2;
  logic [2:0] state2;
  logic [1:0] iter_cnt2;
  logic [6:0] outs;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  assign outs = {load_cnt, en_cnt, load_reg, sel, oe, done, err};

  fact_cu #(.ITER_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .go(go), .gt_in(gt_in), .gt(gt),
    .load_cnt(load_cnt), .en_cnt(en_cnt), .load_reg(load_reg), .sel(sel),
    .oe(oe), .done(done), .err(err), .state(state), .iter_cnt(iter_cnt)
  );

  fact_cu #(.ITER_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .go(go), .gt_in(gt_in), .gt(gt),
    .load_cnt(load_cnt2), .en_cnt(en_cnt2), .load_reg(load_reg2), .sel(sel2),
    .oe(oe2), .done(done2), .err(err2), .state(state2), .iter_cnt(iter_cnt2)
  );

  // Expected {load_cnt,en_cnt,load_reg,sel,oe,done,err} for a given state.
  function automatic logic [6:0] exp_outs(input logic [2:0] s);
    case (s)
      3'd1:    return 7'b1011000;
      3'd3:    return 7'b0110000;
      3'd4:    return 7'b0000110;
      3'd5:    return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [3:0] exp_iter(input int unsigned n, input int unsigned maxv);
`ifdef FACT_CU_ITER_CNT_EN
    return 4'((n > maxv) ? maxv : n);
`else
    return 4'(0 * n * maxv);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; gt_in = 1'b0; gt = 1'b0;
    step(); step();
    rst = 1'b0;
    ntotal++;
    if ({state, outs, iter_cnt} !== {3'd0, 7'b0, 4'd0})
      $display("FAIL reset: state=%0d outs=%b iter=%0d, want 0/0000000/0", state, outs, iter_cnt);
    else npass++;
  endtask

  task automatic test_run_n5();
    logic [2:0] seq [7] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd4};
    logic gts [3] = '{1'b1, 1'b1, 1'b0};
    int unsigned gi = 0;
    go = 1'b1; gt_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      ntotal++;
      if ({state, outs} !== {seq[i], exp_outs(seq[i])})
        $display("FAIL run_n5 cycle %0d: state=%0d outs=%b, want %0d/%b",
                 i + 1, state, outs, seq[i], exp_outs(seq[i]));
      else npass++;
      if (state == 3'd2 && gi < 3) begin gt = gts[gi]; gi++; end
      else gt = ~gt;
      // go and gt_in wiggle while go/gt_in are not sampled
      gt_in = 1'b1;
      go = (i < 5) ? i[0] : 1'b1;
    end
    ntotal++;
    if (iter_cnt !== exp_iter(2, 15))
      $display("FAIL run_n5 iter_cnt: got %0d want %0d", iter_cnt, exp_iter(2, 15));
    else npass++;
  endtask

  task automatic test_held_go();
    int unsigned loads = 0;
    gt_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      ntotal++;
      if ({state, done, load_cnt} !== {3'd4, 1'b1, 1'b0})
        $display("FAIL held_go %0d: state=%0d done=%b load_cnt=%b, want 4/1/0", i, state, done, load_cnt);
      else npass++;
    end
    go = 1'b0;
    step();
    ntotal++;
    if ({state, outs} !== {3'd0, 7'b0})
      $display("FAIL held_go release: state=%0d outs=%b, want 0/0000000", state, outs);
    else npass++;
    go = 1'b1; gt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (load_cnt) loads++;
    end
    ntotal++;
    if ({state, loads} !== {3'd4, 32'd1})
      $display("FAIL held_go restart: state=%0d load pulses=%0d, want 4/1", state, loads);
    else npass++;
    go = 1'b0;
    step();
  endtask

  task automatic test_err();
    logic [3:0] held;
    held = iter_cnt;
    go = 1'b1; gt_in = 1'b1;
    step();
    ntotal++;
    if ({state, err, done, oe} !== {3'd5, 1'b1, 1'b0, 1'b0})
      $display("FAIL err entry: state=%0d err=%b done=%b oe=%b, want 5/1/0/0", state, err, done, oe);
    else npass++;
    gt_in = 1'b0;
    step(); step();
    ntotal++;
    if ({state, outs, iter_cnt} !== {3'd5, exp_outs(3'd5), held})
      $display("FAIL err hold: state=%0d outs=%b iter=%0d, want 5/%b/%0d", state, outs, iter_cnt, exp_outs(3'd5), held);
    else npass++;
    go = 1'b0;
    step();
    ntotal++;
    if ({state, err} !== {3'd0, 1'b0})
      $display("FAIL err release: state=%0d err=%b, want 0/0", state, err);
    else npass++;
  endtask

  task automatic test_trivial();
    go = 1'b1; gt_in = 1'b0; gt = 1'b1;
    step();
    gt = 1'b0;
    step();
    ntotal++;
    if ({state, outs} !== {3'd2, 7'b0})
      $display("FAIL trivial check: state=%0d outs=%b, want 2/0000000", state, outs);
    else npass++;
    step();
    ntotal++;
    if ({state, done, oe, iter_cnt} !== {3'd4, 1'b1, 1'b1, 4'd0})
      $display("FAIL trivial done: state=%0d done=%b oe=%b iter=%0d, want 4/1/1/0", state, done, oe, iter_cnt);
    else npass++;
    go = 1'b0;
    step();
  endtask

  task automatic test_reset_midrun();
    go = 1'b1; gt_in = 1'b0; gt = 1'b1;
    step(); step(); step();
    ntotal++;
    if (state !== 3'd3)
      $display("FAIL midrun setup: state=%0d want 3", state);
    else npass++;
    rst = 1'b1;
    step();
    rst = 1'b0; go = 1'b0;
    ntotal++;
    if ({state, outs, iter_cnt} !== {3'd0, 7'b0, 4'd0})
      $display("FAIL midrun reset: state=%0d outs=%b iter=%0d, want 0/0000000/0", state, outs, iter_cnt);
    else npass++;
    for (int i = 0; i < 4; i++) begin
      gt = ~gt;
      step();
    end
    ntotal++;
    if (state !== 3'd0)
      $display("FAIL idle gt toggle: state=%0d want 0", state);
    else npass++;
    go = 1'b1;
    step();
    ntotal++;
    if ({state, load_cnt} !== {3'd1, 1'b1})
      $display("FAIL fresh run: state=%0d load_cnt=%b, want 1/1", state, load_cnt);
    else npass++;
    gt = 1'b0;
    step(); step();
    go = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    go = 1'b1; gt_in = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      gt = 1'b1;
      step();
    end
    step();
    gt = 1'b0;
    step();
    ntotal++;
    if ({state, iter_cnt} !== {3'd4, exp_iter(5, 15)})
      $display("FAIL sat main: state=%0d iter=%0d, want 4/%0d", state, iter_cnt, exp_iter(5, 15));
    else npass++;
    ntotal++;
    if ({state2, 2'(iter_cnt2)} !== {3'd4, 2'(exp_iter(5, 3))})
      $display("FAIL sat width2: state=%0d iter=%0d, want 4/%0d", state2, iter_cnt2, exp_iter(5, 3));
    else npass++;
    go = 1'b0;
    step();
    ntotal++;
    if ({state, iter_cnt} !== {3'd0, exp_iter(5, 15)})
      $display("FAIL sat idle hold: state=%0d iter=%0d, want 0/%0d", state, iter_cnt, exp_iter(5, 15));
    else npass++;
  endtask

  initial begin
    #2;
    test_reset();
    test_run_n5();
    test_held_go();
    test_err();
    test_trivial();
    test_reset_midrun();
    test_saturation();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
